ocm_atomic_unit: RTL and testbench
==================================

// Module: ocm_atomic_unit
// PURPOSE
//  Sits on the OCM port, downstream of the memory address router.
//  Plain OCM reads and writes pass through to the OCM BRAM.
//  Atomic requests are turned into a locked read-modify-write sequence on the BRAM:
//   - AMO ops: SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
//   - LR/SC via a single reservation register.
//  The core is stalled until the old value is returned.
// PARAMETERS
//  ADDR_BITS   12   width of OCM word address (already word-shifted by router)
//  DATA_BITS   32   data width; AMO ALU operates on full word
// PORTS
//  clk             in   1          system clock
//  nrst            in   1          asynchronous active-low reset
//  i_addr          in   ADDR_BITS  OCM word address from router
//  i_data          in   32         store data / AMO rs2 operand
//  i_dm_write      in   4          byte enables for plain writes
//  i_wr            in   1          plain write request
//  i_rd            in   1          plain read request
//  i_atomic_lock   in   1          request is atomic (from router)
//  i_amo_op        in   5          RISC-V funct5 of the atomic instruction
//  i_snoop_wr      in   1          write to OCM by another master this cycle
//  i_snoop_addr    in   ADDR_BITS  word address of that write
//  o_stall         out  1          hold core pipeline
//  o_rdata         out  32         data to core (plain read or AMO/LR old value, SC status)
//  o_mem_addr      out  ADDR_BITS  BRAM address
//  o_mem_wdata     out  32         BRAM write data
//  o_mem_we        out  4          BRAM byte write enables
//  o_mem_en        out  1          BRAM enable
//  o_mem_lock      out  1          OCM arbiter lock, held across the RMW
//  i_mem_rdata     in   32         BRAM read data, valid 1 cycle after o_mem_en
// BEHAVIOUR
//  Reset: state=IDLE, res_valid=0, res_addr=0, all outputs 0.
//  Reset mid-sequence aborts immediately; no pending write is issued afterwards.
//  IDLE, atomic=0: combinational pass-through.
//   - o_mem_addr=i_addr, o_mem_en=i_rd|i_wr, o_mem_we=i_wr?i_dm_write:0,
//     o_mem_wdata=i_data, o_rdata=i_mem_rdata, o_stall=0.
//   - Plain write whose address matches res_addr clears res_valid.
//  IDLE, atomic=1: latch addr/data/op; o_stall=1 combinationally in that same cycle.
//  FSM states: IDLE, RD, CALC, WR, DONE.
//   - IDLE -> RD: o_mem_en=1, o_mem_lock=1, we=0.
//   - RD -> CALC: old = i_mem_rdata registered.
//   - CALC -> WR (AMO, or SC with valid reservation); CALC -> DONE (LR, failed SC, unknown op).
//   - WR: we=4'hF, wdata=result, lock=1.
//   - DONE: o_stall=0, o_rdata=ret for exactly 1 cycle, lock=0, then IDLE.
//  Latency: AMO and SC-success stall 4 cycles; LR and SC-fail stall 3 cycles.
//  o_mem_lock is high from RD through WR inclusive.
//  AMO ops on registered old and latched operand (op2):
//   - ADD: 32-bit, wraps mod 2^32.
//   - MIN/MAX: signed compare. MINU/MAXU: unsigned compare.
//   - ret=old.
//  LR (00010): res_valid<=1, res_addr<=addr, ret=old, no write.
//  SC (00011):
//   - success iff res_valid && res_addr==addr at CALC: write op2, ret=0.
//   - otherwise no write, ret=1.
//   - res_valid<=0 in either case.
//  Snoop: i_snoop_wr with i_snoop_addr==res_addr clears res_valid in any state.
//   - Snoop in the same cycle as SC's CALC -> SC fails.
//  Unknown funct5: read only, ret=old, no write.
//  Plain i_rd/i_wr while not IDLE are ignored; the core is stalled, so none arrive.
// STRUCTURE
//  Shared header amo_defs.vh:
//   - funct5 constants AMO_ADD=00000, SWAP=00001, LR=00010, SC=00011,
//     XOR=00100, OR=01000, AND=01100, MIN=10000, MAX=10100,
//     MINU=11000, MAXU=11100.
//   - FSM state encodings.
//  Sub-module amo_alu: purely combinational (op, old, op2) -> result; reused by the cache path.
// TESTING
//  1. Reset: nrst low mid-WR -> no we pulse after release; all outputs 0; res_valid=0.
//  2. AMOADD: mem[0x10]=0x7FFFFFFF, op2=1 -> o_rdata=0x7FFFFFFF; mem becomes 0x80000000;
//     stall exactly 4 cycles; lock high 3 cycles.
//  3. AMOMIN vs AMOMINU: mem=0xFFFFFFFF, op2=5 -> MIN leaves 0xFFFFFFFF; MINU writes 5.
//     Both return 0xFFFFFFFF.
//  4. LR 0x20 then SC 0x20 data 0xAB -> SC o_rdata=0, mem=0xAB;
//     second SC with no new LR -> o_rdata=1, no write.
//  5. LR 0x20; snoop write 0x20 (also repeat with the snoop landing on SC's CALC cycle)
//     -> SC returns 1, mem unchanged.
//  6. Plain write 0x30 be=4'b0011, then read -> zero stall; only low halfword updated;
//     LR-reserved 0x30 invalidated.

Source files
------------

// File: rtl/ocm_atomic_unit_pkg.sv
// Shared definitions for the OCM atomic unit: RISC-V AMO funct5 codes,
// FSM state encodings and op classification.
package ocm_atomic_unit_pkg;

  localparam int unsigned FUNCT5_BITS = 5;

  localparam logic [FUNCT5_BITS-1:0] AMO_ADD  = 5'b00000;
  localparam logic [FUNCT5_BITS-1:0] AMO_SWAP = 5'b00001;
  localparam logic [FUNCT5_BITS-1:0] AMO_LR   = 5'b00010;
  localparam logic [FUNCT5_BITS-1:0] AMO_SC   = 5'b00011;
  localparam logic [FUNCT5_BITS-1:0] AMO_XOR  = 5'b00100;
  localparam logic [FUNCT5_BITS-1:0] AMO_OR   = 5'b01000;
  localparam logic [FUNCT5_BITS-1:0] AMO_AND  = 5'b01100;
  localparam logic [FUNCT5_BITS-1:0] AMO_MIN  = 5'b10000;
  localparam logic [FUNCT5_BITS-1:0] AMO_MAX  = 5'b10100;
  localparam logic [FUNCT5_BITS-1:0] AMO_MINU = 5'b11000;
  localparam logic [FUNCT5_BITS-1:0] AMO_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CALC = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } amo_state_e;

  // True for ops that always write back a result (everything except LR/SC/unknown).
  function automatic logic is_rmw_op(input logic [FUNCT5_BITS-1:0] op);
    case (op)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: is_rmw_op = 1'b1;
      default:                              is_rmw_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ocm_atomic_unit_amo_alu.sv
// Combinational AMO ALU: (op, old, op2) -> value to write back.
// Shared with the cache atomic path.
module ocm_atomic_unit_amo_alu
  import ocm_atomic_unit_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic [FUNCT5_BITS-1:0] op_i,
  input  logic [DATA_BITS-1:0]   old_i,
  input  logic [DATA_BITS-1:0]   op2_i,
  output logic [DATA_BITS-1:0]   result_o
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(old_i) < $signed(op2_i);
  assign lt_u = old_i < op2_i;

  always_comb begin
    result_o = old_i;
    case (op_i)
      AMO_ADD:          result_o = old_i + op2_i;
      AMO_SWAP, AMO_SC: result_o = op2_i;
      AMO_XOR:          result_o = old_i ^ op2_i;
      AMO_OR:           result_o = old_i | op2_i;
      AMO_AND:          result_o = old_i & op2_i;
      AMO_MIN:          result_o = lt_s ? old_i : op2_i;
      AMO_MAX:          result_o = lt_s ? op2_i : old_i;
      AMO_MINU:         result_o = lt_u ? old_i : op2_i;
      AMO_MAXU:         result_o = lt_u ? op2_i : old_i;
      default:          result_o = old_i;
    endcase
  end

endmodule

// File: rtl/ocm_atomic_unit.sv
// OCM port atomic unit: plain accesses pass straight through; AMO/LR/SC run
// as a locked read-modify-write on the BRAM while the core is stalled.
module ocm_atomic_unit
  import ocm_atomic_unit_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [ADDR_BITS-1:0]     i_addr,
  input  logic [DATA_BITS-1:0]     i_data,
  input  logic [DATA_BITS/8-1:0]   i_dm_write,
  input  logic                     i_wr,
  input  logic                     i_rd,
  input  logic                     i_atomic_lock,
  input  logic [FUNCT5_BITS-1:0]   i_amo_op,
  input  logic                     i_snoop_wr,
  input  logic [ADDR_BITS-1:0]     i_snoop_addr,
  output logic                     o_stall,
  output logic [DATA_BITS-1:0]     o_rdata,
  output logic [ADDR_BITS-1:0]     o_mem_addr,
  output logic [DATA_BITS-1:0]     o_mem_wdata,
  output logic [DATA_BITS/8-1:0]   o_mem_we,
  output logic                     o_mem_en,
  output logic                     o_mem_lock,
  input  logic [DATA_BITS-1:0]     i_mem_rdata
);

  amo_state_e             state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [FUNCT5_BITS-1:0] op_q, op_d;
  logic [DATA_BITS-1:0]   op2_q, op2_d;
  logic [DATA_BITS-1:0]   old_q, old_d;
  logic [DATA_BITS-1:0]   ret_q, ret_d;
  logic                   res_valid_q, res_valid_d;
  logic [ADDR_BITS-1:0]   res_addr_q, res_addr_d;
  logic                   snoop_hit;
  logic                   sc_ok;
  logic [DATA_BITS-1:0]   alu_result;

  ocm_atomic_unit_amo_alu #(.DATA_BITS(DATA_BITS)) u_alu (
    .op_i     (op_q),
    .old_i    (old_q),
    .op2_i    (op2_q),
    .result_o (alu_result)
  );

  assign snoop_hit = i_snoop_wr && (i_snoop_addr == res_addr_q);
  // A snoop landing on the SC decision cycle already kills the reservation.
  assign sc_ok     = res_valid_q && !snoop_hit && (res_addr_q == addr_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    op_d        = op_q;
    op2_d       = op2_q;
    old_d       = old_q;
    ret_d       = ret_q;
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    o_stall     = 1'b0;
    o_rdata     = '0;
    o_mem_addr  = addr_q;
    o_mem_wdata = '0;
    o_mem_we    = '0;
    o_mem_en    = 1'b0;
    o_mem_lock  = 1'b0;

    if (snoop_hit) res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_atomic_lock) begin
          addr_d     = i_addr;
          op_d       = i_amo_op;
          op2_d      = i_data;
          o_stall    = 1'b1;
          o_mem_addr = i_addr;
          state_d    = ST_RD;
        end else begin
          o_mem_addr  = i_addr;
          o_mem_en    = i_rd | i_wr;
          o_mem_we    = i_wr ? i_dm_write : '0;
          o_mem_wdata = i_data;
          o_rdata     = i_mem_rdata;
          if (i_wr && (i_addr == res_addr_q)) res_valid_d = 1'b0;
        end
      end
      ST_RD: begin
        o_stall    = 1'b1;
        o_mem_en   = 1'b1;
        o_mem_lock = 1'b1;
        state_d    = ST_CALC;
      end
      ST_CALC: begin
        o_stall    = 1'b1;
        o_mem_lock = 1'b1;
        old_d      = i_mem_rdata;
        ret_d      = i_mem_rdata;
        if (op_q == AMO_LR) begin
          res_valid_d = 1'b1;
          res_addr_d  = addr_q;
          state_d     = ST_DONE;
        end else if (op_q == AMO_SC) begin
          res_valid_d = 1'b0;
          ret_d       = sc_ok ? '0 : DATA_BITS'(1);
          state_d     = sc_ok ? ST_WR : ST_DONE;
        end else begin
          state_d = is_rmw_op(op_q) ? ST_WR : ST_DONE;
        end
      end
      ST_WR: begin
        o_stall     = 1'b1;
        o_mem_en    = 1'b1;
        o_mem_we    = '1;
        o_mem_wdata = alu_result;
        o_mem_lock  = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        o_rdata = ret_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs read as zero while reset is held, independent of the inputs.
    if (!nrst) begin
      o_stall     = 1'b0;
      o_rdata     = '0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_we    = '0;
      o_mem_en    = 1'b0;
      o_mem_lock  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      op2_q       <= '0;
      old_q       <= '0;
      ret_q       <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      op2_q       <= op2_d;
      old_q       <= old_d;
      ret_q       <= ret_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
    end
  end

endmodule

// File: tb/tb_ocm_atomic_unit.sv
// Self-checking bench for ocm_atomic_unit: BRAM model, reference memory and
// reservation model, directed scenarios plus a randomized op mix.
module tb_ocm_atomic_unit;
  import ocm_atomic_unit_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [3:0]    dm;
  logic          wr, rd, atomic;
  logic [4:0]    amo_op;
  logic          snoop_wr;
  logic [AW-1:0] snoop_addr;
  logic          stall;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_we;
  logic          mem_en, mem_lock;
  logic [DW-1:0] mem_rdata;

  logic          bk_en;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_data;
  logic [DW-1:0] bram    [0:4095];
  logic [DW-1:0] exp_mem [0:4095];
  logic          m_res_valid;
  logic [AW-1:0] m_res_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ocm_atomic_unit dut (
    .clk(clk), .nrst(nrst), .i_addr(addr), .i_data(data), .i_dm_write(dm),
    .i_wr(wr), .i_rd(rd), .i_atomic_lock(atomic), .i_amo_op(amo_op),
    .i_snoop_wr(snoop_wr), .i_snoop_addr(snoop_addr), .o_stall(stall),
    .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_en(mem_en), .o_mem_lock(mem_lock),
    .i_mem_rdata(mem_rdata)
  );

  // Synchronous BRAM: read data appears the cycle after en, byte-enabled writes.
  always @(posedge clk) begin
    if (bk_en) bram[bk_addr] <= bk_data;
    else if (mem_en) begin
      mem_rdata <= bram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] ref_amo(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      AMO_ADD:  return a + b;
      AMO_SWAP: return b;
      AMO_XOR:  return a ^ b;
      AMO_OR:   return a | b;
      AMO_AND:  return a & b;
      AMO_MIN:  return (sa <= sb) ? a : b;
      AMO_MAX:  return (sa >= sb) ? a : b;
      AMO_MINU: return (a <= b) ? a : b;
      AMO_MAXU: return (a >= b) ? a : b;
      default:  return a;
    endcase
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    bk_en = 1'b1; bk_addr = a; bk_data = v;
    @(posedge clk); #1;
    bk_en = 1'b0;
    exp_mem[a] = v;
  endtask

  // Drive one atomic request and observe it until the core is released.
  task automatic run_op(input logic [4:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int snoop_at, input logic [AW-1:0] sa, input bit kill,
                        output logic [DW-1:0] o_ret, output int o_st, output int o_lk, output int o_we,
                        output logic [DW-1:0] e_ret, output int e_st, output int e_lk, output int e_we);
    int cyc;
    bit done;
    bit writes;
    logic [DW-1:0] old;
    @(posedge clk); #1;
    atomic = 1'b1; amo_op = op; addr = a; data = d;
    o_st = 0; o_lk = 0; o_we = 0; cyc = 0; done = 0; o_ret = 'x;
    while (!done && cyc < 20) begin
      snoop_wr = (cyc == snoop_at); snoop_addr = sa;
      @(negedge clk);
      if (stall) o_st++;
      if (mem_lock) o_lk++;
      if (|mem_we) o_we++;
      if (!stall) begin o_ret = rdata; done = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    snoop_wr = 1'b0; atomic = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout op=%b addr=%h: stall still high after %0d cycles, required release", op, a, cyc);
    end
    old = exp_mem[a];
    writes = 0;
    if (op == AMO_LR) begin
      m_res_valid = 1'b1; m_res_addr = a; e_ret = old;
    end else if (op == AMO_SC) begin
      writes = m_res_valid && (m_res_addr == a) && !kill;
      m_res_valid = 1'b0;
      e_ret = writes ? 32'd0 : 32'd1;
      if (writes) exp_mem[a] = d;
    end else if (is_rmw_op(op)) begin
      writes = 1; e_ret = old; exp_mem[a] = ref_amo(op, old, d);
    end else begin
      e_ret = old;
    end
    e_st = writes ? 4 : 3;
    e_lk = writes ? 3 : 2;
    e_we = writes ? 1 : 0;
  endtask

  task automatic plain_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be,
                             output logic st);
    @(posedge clk); #1;
    wr = 1'b1; addr = a; data = d; dm = be;
    @(negedge clk); st = stall;
    @(posedge clk); #1;
    wr = 1'b0; dm = '0;
    for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    if (a == m_res_addr) m_res_valid = 1'b0;
  endtask

  task automatic plain_read(input logic [AW-1:0] a, output logic [DW-1:0] v, output logic st);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    @(negedge clk); st = stall;
    @(posedge clk); #1;
    rd = 1'b0;
    @(negedge clk); v = rdata;
  endtask

  task automatic snoop_pulse(input logic [AW-1:0] a);
    @(posedge clk); #1;
    snoop_wr = 1'b1; snoop_addr = a;
    @(posedge clk); #1;
    snoop_wr = 1'b0;
    if (a == m_res_addr) m_res_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; addr = '0; data = '0; dm = '0; wr = 0; rd = 0; atomic = 0; amo_op = '0;
    snoop_wr = 0; snoop_addr = '0; bk_en = 0; bk_addr = '0; bk_data = '0;
    m_res_valid = 1'b0; m_res_addr = '0;
    #2;
    checks++;
    if ({stall, rdata, mem_addr, mem_wdata, mem_we, mem_en, mem_lock} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b rdata=%h addr=%h we=%h en=%b lock=%b, required all 0",
               stall, rdata, mem_addr, mem_we, mem_en, mem_lock);
    end
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic test_amo_add();
    logic [DW-1:0] r, er; int s, l, w, es, el, ew;
    load(12'h010, 32'h7FFF_FFFF);
    run_op(AMO_ADD, 12'h010, 32'd1, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'h7FFF_FFFF) begin failures++; $display("FAIL add_ret: got %h want 7fffffff", r); end
    checks++; if (bram[12'h010] !== 32'h8000_0000) begin failures++; $display("FAIL add_mem: got %h want 80000000", bram[12'h010]); end
    checks++; if (s !== 4) begin failures++; $display("FAIL add_stall: got %0d want 4", s); end
    checks++; if (l !== 3) begin failures++; $display("FAIL add_lock: got %0d want 3", l); end
    checks++; if (w !== ew) begin failures++; $display("FAIL add_we: got %0d want %0d", w, ew); end
  endtask

  task automatic test_min_minu();
    logic [DW-1:0] r, er; int s, l, w, es, el, ew;
    load(12'h011, 32'hFFFF_FFFF);
    run_op(AMO_MIN, 12'h011, 32'd5, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL min_ret: got %h want ffffffff", r); end
    checks++; if (bram[12'h011] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL min_mem: got %h want ffffffff", bram[12'h011]); end
    load(12'h011, 32'hFFFF_FFFF);
    run_op(AMO_MINU, 12'h011, 32'd5, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL minu_ret: got %h want ffffffff", r); end
    checks++; if (bram[12'h011] !== 32'd5) begin failures++; $display("FAIL minu_mem: got %h want 00000005", bram[12'h011]); end
  endtask

  task automatic test_lr_sc();
    logic [DW-1:0] r, er; int s, l, w, es, el, ew;
    load(12'h020, 32'h1234_0000);
    run_op(AMO_LR, 12'h020, '0, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'h1234_0000 || s !== 3) begin failures++; $display("FAIL lr_ret: got %h/%0d want 12340000/3", r, s); end
    run_op(AMO_SC, 12'h020, 32'hAB, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'd0 || s !== 4) begin failures++; $display("FAIL sc_ok_ret: got %h/%0d want 0/4", r, s); end
    checks++; if (bram[12'h020] !== 32'hAB) begin failures++; $display("FAIL sc_ok_mem: got %h want 000000ab", bram[12'h020]); end
    run_op(AMO_SC, 12'h020, 32'hCD, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'd1 || w !== 0 || s !== 3) begin failures++; $display("FAIL sc_again: got ret=%h we=%0d stall=%0d want 1/0/3", r, w, s); end
    checks++; if (bram[12'h020] !== 32'hAB) begin failures++; $display("FAIL sc_again_mem: got %h want 000000ab", bram[12'h020]); end
  endtask

  task automatic test_snoop();
    logic [DW-1:0] r, er; int s, l, w, es, el, ew;
    run_op(AMO_LR, 12'h020, '0, -1, '0, 0, r, s, l, w, er, es, el, ew);
    snoop_pulse(12'h020);
    run_op(AMO_SC, 12'h020, 32'h55, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== er || w !== 0) begin failures++; $display("FAIL snoop_idle_sc: got ret=%h we=%0d want %h/0", r, w, er); end
    run_op(AMO_LR, 12'h020, '0, -1, '0, 0, r, s, l, w, er, es, el, ew);
    run_op(AMO_SC, 12'h020, 32'h66, 2, 12'h020, 1, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'd1 || w !== 0) begin failures++; $display("FAIL snoop_calc_sc: got ret=%h we=%0d want 1/0", r, w); end
    checks++; if (bram[12'h020] !== exp_mem[12'h020]) begin failures++; $display("FAIL snoop_mem: got %h want %h", bram[12'h020], exp_mem[12'h020]); end
    run_op(AMO_LR, 12'h020, '0, -1, '0, 0, r, s, l, w, er, es, el, ew);
    run_op(AMO_SC, 12'h020, 32'h77, 2, 12'h021, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'd0 || bram[12'h020] !== 32'h77) begin failures++; $display("FAIL snoop_other_sc: got ret=%h mem=%h want 0/00000077", r, bram[12'h020]); end
  endtask

  task automatic test_plain();
    logic [DW-1:0] r, er, v; int s, l, w, es, el, ew; logic st;
    load(12'h030, 32'hAABB_CCDD);
    run_op(AMO_LR, 12'h030, '0, -1, '0, 0, r, s, l, w, er, es, el, ew);
    plain_write(12'h030, 32'h1234_5678, 4'b0011, st);
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL plain_wr_stall: got %b want 0", st); end
    plain_read(12'h030, v, st);
    checks++; if (v !== 32'hAABB_5678 || st !== 1'b0) begin failures++; $display("FAIL plain_rd: got %h stall=%b want aabb5678 stall=0", v, st); end
    run_op(AMO_SC, 12'h030, 32'h99, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'd1 || bram[12'h030] !== 32'hAABB_5678) begin failures++; $display("FAIL plain_inval_sc: got ret=%h mem=%h want 1/aabb5678", r, bram[12'h030]); end
  endtask

  task automatic test_reset_mid_wr();
    logic [DW-1:0] r, er; int s, l, w, es, el, ew; int wes;
    load(12'h040, 32'h1111_1111);
    run_op(AMO_LR, 12'h040, '0, -1, '0, 0, r, s, l, w, er, es, el, ew);
    @(posedge clk); #1;
    atomic = 1'b1; amo_op = AMO_ADD; addr = 12'h040; data = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_we !== 4'hF) begin failures++; $display("FAIL pre_reset_wr: we=%h want f", mem_we); end
    nrst = 1'b0; atomic = 1'b0; addr = '0; data = '0; amo_op = '0;
    #1;
    checks++;
    if ({stall, rdata, mem_addr, mem_wdata, mem_we, mem_en, mem_lock} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: stall=%b rdata=%h we=%h en=%b lock=%b, required all 0",
               stall, rdata, mem_we, mem_en, mem_lock);
    end
    m_res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    wes = 0;
    repeat (5) begin @(negedge clk); if (|mem_we) wes++; end
    checks++; if (wes !== 0) begin failures++; $display("FAIL post_reset_we: got %0d pulses want 0", wes); end
    checks++; if (bram[12'h040] !== 32'h1111_1111) begin failures++; $display("FAIL post_reset_mem: got %h want 11111111", bram[12'h040]); end
    run_op(AMO_SC, 12'h040, 32'h22, -1, '0, 0, r, s, l, w, er, es, el, ew);
    checks++; if (r !== 32'd1 || w !== 0) begin failures++; $display("FAIL post_reset_sc: got ret=%h we=%0d want 1/0", r, w); end
  endtask

  task automatic test_random();
    logic [4:0] ops [12] = '{AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND, AMO_MIN,
                             AMO_MAX, AMO_MINU, AMO_MAXU, AMO_LR, AMO_SC, 5'b00101};
    logic [DW-1:0] r, er, d; int s, l, w, es, el, ew; logic st;
    logic [AW-1:0] a;
    int k;
    for (int i = 0; i < 4; i++) load(AW'(12'h050 + i), $urandom);
    for (int i = 0; i < 60; i++) begin
      a = AW'(12'h050 + $urandom_range(0, 3));
      d = (i % 3 == 0) ? {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)} : $urandom;
      k = $urandom_range(0, 12);
      if (k == 12) begin
        plain_write(a, d, 4'($urandom_range(1, 15)), st);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL rnd_wr_stall[%0d]: got %b want 0", i, st); end
      end else begin
        run_op(ops[k], a, d, -1, '0, 0, r, s, l, w, er, es, el, ew);
        checks++;
        if (r !== er || s !== es || l !== el || w !== ew) begin
          failures++;
          $display("FAIL rnd_op[%0d] op=%b addr=%h: ret=%h stall=%0d lock=%0d we=%0d want %h/%0d/%0d/%0d",
                   i, ops[k], a, r, s, l, w, er, es, el, ew);
        end
      end
      checks++;
      if (bram[a] !== exp_mem[a]) begin failures++; $display("FAIL rnd_mem[%0d] addr=%h: got %h want %h", i, a, bram[a], exp_mem[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_amo_add();
    test_min_minu();
    test_lr_sc();
    test_snoop();
    test_plain();
    test_reset_mid_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
